// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio widths, request FSM encoding and counter helper
package audio_pkg;

  localparam int SAMPLE_W = 16;

  // 45.1584 MHz board clock / 44.1 kHz = 1024 cycles per sample
  localparam int BOARD_CLK_HZ       = 45_158_400;
  localparam int SAMPLE_RATE_HZ     = 44_100;
  localparam int DEFAULT_SAMPLE_DIV = BOARD_CLK_HZ / SAMPLE_RATE_HZ;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } req_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - first-word fall-through circular sample buffer
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign do_pop    = pop && out_valid;
  // A pop in the same cycle frees the slot, so a push at full is still safe
  assign do_push   = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (!do_push && do_pop) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;

endmodule

// File: rtl/sample_requester.sv
// rtl/sample_requester.sv - paced generate_next/sample_ready initiator feeding a sample FIFO
module sample_requester
  import audio_pkg::*;
#(
  parameter int WIDTH      = SAMPLE_W,
  parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
  parameter int TIMEOUT    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  output logic                          generate_next,
  input  logic                          sample_ready,
  input  logic [WIDTH-1:0]              sample,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_sample,
  input  logic                          out_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    timeout_cnt,
  output logic [7:0]                    overrun_cnt
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  req_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              gen_q, gen_d;
  logic [7:0]        timeout_q, timeout_d;
  logic [7:0]        overrun_q, overrun_d;
  logic              tick;
  logic              push;
  logic [WIDTH-1:0]  push_data;
  logic              fifo_full;

  always_comb begin
    div_d = div_q;
    tick  = 1'b0;
    if (enable) begin
      if (div_q == DIV_W'(SAMPLE_DIV - 1)) begin
        div_d = '0;
        tick  = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Ticks outside IDLE cannot occur because SAMPLE_DIV exceeds a full request
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    push      = 1'b0;
    push_data = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          if (fifo_full) begin
            overrun_d = sat_inc8(overrun_q);
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sample_ready) begin
          push      = 1'b1;
          push_data = sample;
          state_d   = ST_IDLE;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          push      = 1'b1;
          timeout_d = sat_inc8(timeout_q);
          state_d   = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    gen_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      wait_q    <= '0;
      gen_q     <= 1'b0;
      timeout_q <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      wait_q    <= wait_d;
      gen_q     <= gen_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ack),
    .out_valid (out_valid),
    .out_data  (out_sample),
    .level     (fifo_level),
    .full      (fifo_full)
  );

  assign generate_next = gen_q;
  assign timeout_cnt   = timeout_q;
  assign overrun_cnt   = overrun_q;

endmodule
